// File: rtl/axi4_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter.
// Master 0 (IFU) only reads; master 1 (LSU) reads and writes.
// One transaction is outstanding at a time. Requests are granted round-robin,
// and the granted master's channels are forwarded combinationally until the
// response handshake completes.
module axi4_lite_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (IFU) read address / data
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    // master 1 (LSU) read address / data
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    // master 1 (LSU) write address / data / response
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    // slave (SRAM) port
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    // debug: 00 idle, 01 m0 read, 10 m1 read, 11 m1 write
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;

    logic   req0, req1, pick1;

    assign req0  = m0_arvalid;
    assign req1  = m1_arvalid | m1_awvalid;
    // m1 wins if it is the only requester, or on a conflict when m0 was last served
    assign pick1 = req1 & (~req0 | ~last_q);

    // State, selected master and round-robin history; last resets to 1 so m0 wins the first conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Arbitration, channel routing and next-state; everything idles at 0
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;

        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = '0;
        m1_bvalid  = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        grant      = 2'b00;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = pick1;
                    last_d  = pick1;
                    // a write pending alongside a read goes first, matching slave priority
                    state_d = (pick1 && m1_awvalid) ? WR : RD;
                end
            end
            RD: begin
                if (sel_q) begin
                    grant      = 2'b10;
                    s_araddr   = m1_araddr;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                    m1_rdata   = s_rdata;
                    m1_rresp   = s_rresp;
                    m1_rvalid  = s_rvalid;
                    s_rready   = m1_rready;
                end else begin
                    grant      = 2'b01;
                    s_araddr   = m0_araddr;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                    m0_rdata   = s_rdata;
                    m0_rresp   = s_rresp;
                    m0_rvalid  = s_rvalid;
                    s_rready   = m0_rready;
                end
                if (s_rvalid && s_rready) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                grant      = 2'b11;
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid;
                m1_awready = s_awready;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid;
                m1_wready  = s_wready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
                if (s_bvalid && s_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed, table-driven bench for axi4_lite_arbiter.
// Each table row is one clock cycle: inputs are applied after the falling
// edge, outputs compared 1 ns later, then the rising edge advances the DUT.
module tb_axi4_lite_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic                clk;
    logic                rst;
    logic [ADDR_W-1:0]   m0_araddr;
    logic                m0_arvalid;
    logic                m0_arready;
    logic [DATA_W-1:0]   m0_rdata;
    logic [1:0]          m0_rresp;
    logic                m0_rvalid;
    logic                m0_rready;
    logic [ADDR_W-1:0]   m1_araddr;
    logic                m1_arvalid;
    logic                m1_arready;
    logic [DATA_W-1:0]   m1_rdata;
    logic [1:0]          m1_rresp;
    logic                m1_rvalid;
    logic                m1_rready;
    logic [ADDR_W-1:0]   m1_awaddr;
    logic                m1_awvalid;
    logic                m1_awready;
    logic [DATA_W-1:0]   m1_wdata;
    logic [DATA_W/8-1:0] m1_wstrb;
    logic                m1_wvalid;
    logic                m1_wready;
    logic [1:0]          m1_bresp;
    logic                m1_bvalid;
    logic                m1_bready;
    logic [ADDR_W-1:0]   s_awaddr;
    logic                s_awvalid;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wvalid;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready;
    logic [ADDR_W-1:0]   s_araddr;
    logic                s_arvalid;
    logic                s_arready;
    logic [DATA_W-1:0]   s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready;
    logic [1:0]          grant;

    axi4_lite_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .m1_awaddr  (m1_awaddr),
        .m1_awvalid (m1_awvalid),
        .m1_awready (m1_awready),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_wvalid  (m1_wvalid),
        .m1_wready  (m1_wready),
        .m1_bresp   (m1_bresp),
        .m1_bvalid  (m1_bvalid),
        .m1_bready  (m1_bready),
        .s_awaddr   (s_awaddr),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .grant      (grant)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  bits: {m0_arv, m1_arv, m1_awv, m1_wv | s_arr, s_awr, s_wr, s_rv | s_bv, m0_rr, m1_rr, m1_br}
    // out bits: {s_arv, s_awv, s_wv, s_rr | s_br, m0_rv, m1_rv, m1_bv | m0_arr, m1_arr, m1_awr, m1_wr}
    typedef struct {
        string        name;
        logic [11:0]  in;
        logic [1:0]   grant;
        logic [11:0]  out;
        logic [31:0]  araddr;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_0100;

    function automatic vec_t v(input string n, input logic [11:0] i, input logic [1:0] g,
                               input logic [11:0] o, input logic [31:0] a);
        vec_t r;
        r.name = n; r.in = i; r.grant = g; r.out = o; r.araddr = a;
        return r;
    endfunction

    task automatic apply(input logic [11:0] i);
        {m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid,
         s_arready, s_awready, s_wready, s_rvalid,
         s_bvalid, m0_rready, m1_rready, m1_bready} = i;
    endtask

    function automatic logic [11:0] outs();
        return {s_arvalid, s_awvalid, s_wvalid, s_rready,
                s_bready, m0_rvalid, m1_rvalid, m1_bvalid,
                m0_arready, m1_arready, m1_awready, m1_wready};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance one full cycle, returning just after the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        m0_araddr = A0;
        m1_araddr = A1;
        m1_awaddr = 32'h8000_0010;
        m1_wdata  = 32'h1234_5678;
        m1_wstrb  = 4'b0011;
        s_rdata   = 32'hDEAD_BEEF;
        s_rresp   = 2'b00;
        s_bresp   = 2'b00;
        apply(12'h000);

        // reset idle, m0 single read
        tv.push_back(v("idle",        12'b0000_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("m0_req",      12'b1000_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("m0_ar",       12'b1000_1000_0000, 2'b01, 12'b1000_0000_1000, A0));
        tv.push_back(v("m0_r",        12'b0000_0001_0100, 2'b01, 12'b0001_0100_0000, A0));
        tv.push_back(v("m0_done",     12'b0000_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        // m1 write
        tv.push_back(v("m1w_req",     12'b0011_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("m1w_aw",      12'b0011_0110_0000, 2'b11, 12'b0110_0000_0011, 32'h0));
        tv.push_back(v("m1w_b",       12'b0000_0000_1001, 2'b11, 12'b0000_1001_0000, 32'h0));
        // conflict: last=m1, so m0, m1, m0, m1
        tv.push_back(v("rr_req1",     12'b1100_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("rr_m0_ar",    12'b1100_1000_0000, 2'b01, 12'b1000_0000_1000, A0));
        tv.push_back(v("rr_m0_r",     12'b1100_0001_0110, 2'b01, 12'b1001_0100_0000, A0));
        tv.push_back(v("rr_bubble1",  12'b1100_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("rr_m1_ar",    12'b1100_1000_0000, 2'b10, 12'b1000_0000_0100, A1));
        tv.push_back(v("rr_m1_r",     12'b1100_0001_0110, 2'b10, 12'b1001_0010_0000, A1));
        tv.push_back(v("rr_bubble2",  12'b1100_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("rr_m0_r2",    12'b1100_0001_0100, 2'b01, 12'b1001_0100_0000, A0));
        tv.push_back(v("rr_bubble3",  12'b1100_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("rr_m1_r2",    12'b1100_0001_0010, 2'b10, 12'b1001_0010_0000, A1));
        // m1 aw+ar together: write first, then read
        tv.push_back(v("wa_req",      12'b0111_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("wa_aw",       12'b0111_1110_0000, 2'b11, 12'b0110_0000_0011, 32'h0));
        tv.push_back(v("wa_b",        12'b0100_0000_1001, 2'b11, 12'b0000_1001_0000, 32'h0));
        tv.push_back(v("wa_bubble",   12'b0100_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("wa_ar",       12'b0100_1000_0000, 2'b10, 12'b1000_0000_0100, A1));
        tv.push_back(v("wa_r",        12'b0000_0001_0010, 2'b10, 12'b0001_0010_0000, A1));
        // backpressure on m0 read with m1 pending
        tv.push_back(v("bp_req",      12'b1000_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("bp_ar",       12'b1000_1000_0000, 2'b01, 12'b1000_0000_1000, A0));
        for (int k = 0; k < 5; k++)
            tv.push_back(v("bp_stall",12'b0100_0001_0000, 2'b01, 12'b0000_0100_0000, A0));
        tv.push_back(v("bp_r",        12'b0100_0001_0100, 2'b01, 12'b0001_0100_0000, A0));
        tv.push_back(v("bp_bubble",   12'b0100_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));
        tv.push_back(v("bp_m1_ar",    12'b0100_1000_0000, 2'b10, 12'b1000_0000_0100, A1));
        tv.push_back(v("bp_m1_r",     12'b0000_0001_0010, 2'b10, 12'b0001_0010_0000, A1));
        tv.push_back(v("end_idle",    12'b0000_0000_0000, 2'b00, 12'b0000_0000_0000, 32'h0));

        // outputs must already be zero while reset is held
        #2;
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_outs",  {20'd0, outs()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].in);
            #1;
            chk($sformatf("%s[%0d].grant", tv[i].name, i), {30'd0, grant}, {30'd0, tv[i].grant});
            chk($sformatf("%s[%0d].outs", tv[i].name, i), {20'd0, outs()}, {20'd0, tv[i].out});
            chk($sformatf("%s[%0d].araddr", tv[i].name, i), s_araddr, tv[i].araddr);
            step();
        end

        // write payload passthrough and SLVERR on b
        apply(12'b0011_0000_0000);
        step();
        apply(12'b0011_0110_0000);
        s_bresp = 2'b10;
        #1;
        chk("wr_awaddr", s_awaddr, 32'h8000_0010);
        chk("wr_wdata",  s_wdata,  32'h1234_5678);
        chk("wr_wstrb",  {28'd0, s_wstrb}, 32'h3);
        step();
        apply(12'b0000_0000_1001);
        #1;
        chk("wr_bresp",  {30'd0, m1_bresp}, 32'h2);
        step();
        s_bresp = 2'b00;

        // m0 read data with SLVERR passthrough, m1 sees nothing
        apply(12'b1000_0000_0000);
        step();
        apply(12'b0000_0001_0100);
        s_rresp = 2'b10;
        #1;
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m0_rresp", {30'd0, m0_rresp}, 32'h2);
        chk("rd_m1_rdata", m1_rdata, 32'h0);
        step();
        s_rresp = 2'b00;

        // reset asserted mid-write clears everything immediately
        apply(12'b0011_0000_0000);
        step();
        apply(12'b0011_0110_0000);
        #1;
        chk("mid_wr_grant", {30'd0, grant}, 32'h3);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", {30'd0, grant}, 32'h0);
        chk("mid_rst_outs",  {20'd0, outs()}, 32'h0);
        chk("mid_rst_wdata", s_wdata, 32'h0);
        chk("mid_rst_awaddr", s_awaddr, 32'h0);
        @(negedge clk);
        apply(12'h000);
        rst = 1'b0;
        step();
        #1;
        chk("post_rst_grant", {30'd0, grant}, 32'h0);
        chk("post_rst_outs",  {20'd0, outs()}, 32'h0);
        @(negedge clk);

        // after reset last=1, so m0 wins the first conflict
        apply(12'b1100_0000_0000);
        step();
        #1;
        chk("post_rst_rr", {30'd0, grant}, 32'h1);
        @(negedge clk);
        apply(12'b0000_0001_0100);
        step();
        apply(12'h000);
        #1;
        chk("final_idle", {30'd0, grant}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard stop in case anything above stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
